// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions for the store unit, load path and control unit.
package cpu_mem_pkg;

    // Store size encodings as presented on store_size_i.
    localparam logic [1:0] STORE_W = 2'b00;
    localparam logic [1:0] STORE_H = 2'b01;
    localparam logic [1:0] STORE_B = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDone,
        StErr
    } store_state_e;

    // A store is rejected for the reserved size, odd halfword or unaligned word addresses.
    function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11) begin
            bad = 1'b1;
        end else if (size == STORE_H) begin
            bad = addr_lo[0];
        end else if (size == STORE_W) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge: replaces the addressed little-endian lane(s) of an old word.
module byte_lane_merge
    import cpu_mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    // Select the lane(s) to overwrite; untouched lanes pass through unchanged.
    always_comb begin
        merged_o = old_word_i;
        unique case (size_i)
            STORE_W: merged_o = new_data_i;
            STORE_H: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = new_data_i[15:0];
                end else begin
                    merged_o[15:0] = new_data_i[15:0];
                end
            end
            STORE_B: begin
                unique case (addr_lo_i)
                    2'd0: merged_o[7:0]   = new_data_i[7:0];
                    2'd1: merged_o[15:8]  = new_data_i[7:0];
                    2'd2: merged_o[23:16] = new_data_i[7:0];
                    2'd3: merged_o[31:24] = new_data_i[7:0];
                    default: merged_o = old_word_i;
                endcase
            end
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Register-to-memory store path: sw direct write, sh/sb as read-modify-write of the aligned word.
module store_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned MemLatency = 1  // 1..4 cycles from mem_addr_o to valid mem_rdata_i
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  store_size_i,
    input  logic [31:0] address_i,
    input  logic [31:0] reg_data_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        misaligned_o
);

    localparam logic [1:0] CntInit = 2'(MemLatency - 1);

    store_state_e state_q, state_d;
    logic [1:0]   size_q, size_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [31:0]  buf_q, buf_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  merged;

    byte_lane_merge u_merge (
        .old_word_i (buf_q),
        .new_data_i (data_q),
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .merged_o   (merged)
    );

    // State and latched request registers; reset abandons any store in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            buf_q   <= 32'h0;
            cnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: latch only in idle, count down the read latency, capture on the last read edge.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    size_d = store_size_i;
                    addr_d = address_i;
                    data_d = reg_data_i;
                    cnt_d  = CntInit;
                    if (store_misaligned(store_size_i, address_i[1:0])) begin
                        state_d = StErr;
                    end else if (store_size_i == STORE_W) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (cnt_q == 2'd0) begin
                    buf_d   = mem_rdata_i;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from state so reset clears them immediately.
    always_comb begin
        mem_addr_o   = 32'h0;
        mem_wr_o     = 1'b0;
        mem_wdata_o  = 32'h0;
        busy_o       = (state_q != StIdle);
        done_o       = 1'b0;
        misaligned_o = 1'b0;
        unique case (state_q)
            StRead: mem_addr_o = {addr_q[31:2], 2'b00};
            StWrite: begin
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_wr_o    = 1'b1;
                mem_wdata_o = merged;
            end
            StDone: begin
                mem_addr_o = {addr_q[31:2], 2'b00};
                done_o     = 1'b1;
            end
            StErr: begin
                done_o       = 1'b1;
                misaligned_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: one instance with read latency 1, one with latency 3.
module tb_store_unit;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdat = 32'h0;
    logic [31:0] rd_addr = 32'h0, rd_word = 32'h0;

    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
    logic        mem_wr1, busy1, done1, mis1;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic        mem_wr3, busy3, done3, mis3;

    int vectors = 0;
    int miscompares = 0;

    int          wr_cyc, wr_cnt, done_cyc;
    logic [31:0] wd, wa;
    logic        mis;

    always #5 clk = ~clk;

    // Memory returns the programmed word only when the expected aligned address is presented.
    assign mem_rdata1 = (mem_addr1 == rd_addr) ? rd_word : 32'hBAD0_BAD0;
    assign mem_rdata3 = (mem_addr3 == rd_addr) ? rd_word : 32'hBAD0_BAD0;

    store_unit #(.MemLatency(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .store_size_i(size),
        .address_i(addr), .reg_data_i(wdat), .mem_rdata_i(mem_rdata1),
        .mem_addr_o(mem_addr1), .mem_wr_o(mem_wr1), .mem_wdata_o(mem_wdata1),
        .busy_o(busy1), .done_o(done1), .misaligned_o(mis1)
    );

    store_unit #(.MemLatency(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .store_size_i(size),
        .address_i(addr), .reg_data_i(wdat), .mem_rdata_i(mem_rdata3),
        .mem_addr_o(mem_addr3), .mem_wr_o(mem_wr3), .mem_wdata_o(mem_wdata3),
        .busy_o(busy3), .done_o(done3), .misaligned_o(mis3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one store and watch it; cycle k is the k-th falling edge after the start edge.
    // With noise set, start is re-pulsed with a different request through the done cycle.
    task automatic run_store(input bit sel3, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input bit noise);
        logic w, dn;
        wr_cyc = 0; wr_cnt = 0; done_cyc = 0; wd = 'x; wa = 'x; mis = 'x;
        @(negedge clk);
        size = sz; addr = a; wdat = d;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0;
            w  = sel3 ? mem_wr3 : mem_wr1;
            dn = sel3 ? done3 : done1;
            if (w) begin
                wr_cnt++;
                if (wr_cyc == 0) begin
                    wr_cyc = k;
                    wd = sel3 ? mem_wdata3 : mem_wdata1;
                    wa = sel3 ? mem_addr3 : mem_addr1;
                end
            end
            if (dn && done_cyc == 0) begin
                done_cyc = k;
                mis = sel3 ? mis3 : mis1;
            end
            if (noise && (done_cyc == 0 || k == done_cyc)) begin
                size = STORE_B; addr = 32'h0000_0041; wdat = 32'h0000_0055;
                if (sel3) start3 = 1'b1; else start1 = 1'b1;
            end
            if (done_cyc != 0 && k >= done_cyc + 2) break;
        end
        start1 = 1'b0; start3 = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_mem_wr", 32'(mem_wr1), 32'd0);
        check("rst_mem_addr", mem_addr1, 32'h0);
        check("rst_mem_wdata", mem_wdata1, 32'h0);
        check("rst_misaligned", 32'(mis1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. sw
        run_store(1'b0, STORE_W, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        check("sw_wr_cyc", 32'(wr_cyc), 32'd1);
        check("sw_addr", wa, 32'h0000_0010);
        check("sw_wdata", wd, 32'hDEAD_BEEF);
        check("sw_done_cyc", 32'(done_cyc), 32'd2);
        check("sw_mis", 32'(mis), 32'd0);
        check("sw_wr_cnt", 32'(wr_cnt), 32'd1);
        check("sw_idle_addr", mem_addr1, 32'h0);
        check("sw_idle_busy", 32'(busy1), 32'd0);

        // 2. sb to byte 3
        rd_addr = 32'h0000_0010; rd_word = 32'h1122_3344;
        run_store(1'b0, STORE_B, 32'h0000_0013, 32'h0000_00AB, 1'b0);
        check("sb_wr_cyc", 32'(wr_cyc), 32'd2);
        check("sb_addr", wa, 32'h0000_0010);
        check("sb_wdata", wd, 32'hAB22_3344);
        check("sb_done_cyc", 32'(done_cyc), 32'd3);
        check("sb_wr_cnt", 32'(wr_cnt), 32'd1);

        // sb to byte 1
        run_store(1'b0, STORE_B, 32'h0000_0011, 32'hFFFF_FF5A, 1'b0);
        check("sb1_wdata", wd, 32'h1122_5A44);

        // 3. sh upper half, L=1 then L=3
        rd_addr = 32'h0000_0020;
        run_store(1'b0, STORE_H, 32'h0000_0022, 32'h0000_CAFE, 1'b0);
        check("sh_wdata", wd, 32'hCAFE_3344);
        check("sh_addr", wa, 32'h0000_0020);
        check("sh_done_cyc", 32'(done_cyc), 32'd3);
        run_store(1'b1, STORE_H, 32'h0000_0022, 32'h0000_CAFE, 1'b0);
        check("sh3_wr_cyc", 32'(wr_cyc), 32'd4);
        check("sh3_wdata", wd, 32'hCAFE_3344);
        check("sh3_done_cyc", 32'(done_cyc), 32'd5);
        check("sh3_wr_cnt", 32'(wr_cnt), 32'd1);
        // sh lower half
        run_store(1'b1, STORE_H, 32'h0000_0020, 32'h1234_BEEF, 1'b0);
        check("shlo_wdata", wd, 32'h1122_BEEF);

        // 4. Rejected stores
        run_store(1'b0, STORE_W, 32'h0000_0006, 32'h1, 1'b0);
        check("sw_mis_done", 32'(done_cyc), 32'd1);
        check("sw_mis_flag", 32'(mis), 32'd1);
        check("sw_mis_wr", 32'(wr_cnt), 32'd0);
        run_store(1'b0, STORE_H, 32'h0000_0005, 32'h1, 1'b0);
        check("sh_mis_done", 32'(done_cyc), 32'd1);
        check("sh_mis_flag", 32'(mis), 32'd1);
        check("sh_mis_wr", 32'(wr_cnt), 32'd0);
        run_store(1'b0, 2'b11, 32'h0000_0010, 32'h1, 1'b0);
        check("rsv_done", 32'(done_cyc), 32'd1);
        check("rsv_flag", 32'(mis), 32'd1);
        check("rsv_wr", 32'(wr_cnt), 32'd0);

        // 5. start re-pulsed while busy and in done cycle
        rd_addr = 32'h0000_0010;
        run_store(1'b1, STORE_B, 32'h0000_0012, 32'h0000_0077, 1'b1);
        check("busy_start_addr", wa, 32'h0000_0010);
        check("busy_start_wdata", wd, 32'h1177_3344);
        check("busy_start_done", 32'(done_cyc), 32'd5);
        check("busy_start_wr", 32'(wr_cnt), 32'd1);
        check("busy_start_idle", 32'(busy3), 32'd0);

        // 6. Reset during the read phase of an sb
        @(negedge clk);
        size = STORE_B; addr = 32'h0000_0013; wdat = 32'h0000_00AB; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("rstrd_busy_before", 32'(busy1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstrd_busy", 32'(busy1), 32'd0);
        check("rstrd_wr", 32'(mem_wr1), 32'd0);
        check("rstrd_addr", mem_addr1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_wr1) wr_cnt++;
        end
        check("rstrd_no_write", 32'(wr_cnt), 32'd0);
        run_store(1'b0, STORE_W, 32'h0000_0030, 32'h0BAD_F00D, 1'b0);
        check("post_rst_wdata", wd, 32'h0BAD_F00D);
        check("post_rst_addr", wa, 32'h0000_0030);
        check("post_rst_done", 32'(done_cyc), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
